fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage directly upstream of ctrl_unit in the single-cycle RV32I core.
//   - Owns the PC register.
//   - Fetches from instruction memory over a req/ack handshake with variable latency.
//   - Presents a stable instr plus a one-cycle execute strobe to ctrl_unit and the datapath.
//   - Applies ctrl_unit's pc_sel to choose the next PC: ALU target or PC+4.
//   - Halts on illegal instruction, misaligned target or memory timeout.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value loaded on reset.
//   ACK_TIMEOUT  16             Max cycles req may stay unacknowledged; 0 disables the check.
// PORTS
//   i_clk          in   1   Core clock, rising edge.
//   i_reset        in   1   Asynchronous reset, active-low.
//   i_hold         in   1   Debug halt request.
//   o_imem_req     out  1   Fetch request, held high until acknowledged.
//   o_imem_addr    out  32  Fetch address (= o_pc).
//   i_imem_ack     in   1   Memory acknowledge; i_imem_rdata is valid in the same cycle.
//   i_imem_rdata   in   32  Instruction word.
//   o_instr        out  32  Latched instruction, drives ctrl_unit.instr.
//   o_instr_vld    out  1   Execute strobe; the core commits RF/DMEM writes only while it is high.
//   o_pc           out  32  Current PC (opa source for AUIPC/JAL/branches).
//   o_pc_four      out  32  o_pc + 4 (JAL/JALR writeback).
//   i_pc_sel       in   1   From ctrl_unit: 1 = take i_alu_data, 0 = PC+4.
//   i_alu_data     in   32  Branch/jump target computed by the ALU.
//   i_insn_vld     in   1   From ctrl_unit: 1 = decoded instruction is legal.
//   o_trap         out  1   Sticky halt flag.
//   o_trap_cause   out  2   00 none, 01 illegal instr, 10 misaligned target, 11 imem timeout.
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - state = IDLE, o_pc = RESET_PC, o_instr = 32'h0000_0013 (NOP).
//   - o_imem_req = 0, o_instr_vld = 0, o_trap = 0, o_trap_cause = 00, timeout counter = 0.
//   FSM states: IDLE, FETCH, EXEC, HALT, TRAP. All outputs are decoded from registered state.
//   IDLE
//   - Always goes to FETCH on the next edge (one bubble after reset release).
//   FETCH
//   - o_imem_req = 1 and o_imem_addr = o_pc; both stay stable until ack.
//   - On i_imem_ack: o_instr <= i_imem_rdata, next state EXEC.
//   - Ack in the first FETCH cycle is legal, giving fetch latency 1 cycle (FETCH->EXEC).
//   - Without ack: the counter increments.
//   - Counter reaching ACK_TIMEOUT (ACK_TIMEOUT != 0): TRAP, cause 11, req drops.
//   - Counter clears on entry to FETCH.
//   EXEC (exactly one cycle)
//   - o_instr_vld = 1 and o_imem_req = 0. ctrl_unit outputs are sampled at the end of the cycle.
//   - next_pc = i_pc_sel ? i_alu_data : o_pc + 4. Addition is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
//   - Exit priority:
//     1. i_insn_vld == 0: TRAP, cause 01, PC unchanged.
//     2. next_pc[1:0] != 0: TRAP, cause 10, PC unchanged.
//     3. Otherwise o_pc <= next_pc, then HALT if i_hold, else FETCH.
//   HALT
//   - No request. Leaves for FETCH on the first cycle with i_hold == 0.
//   - i_hold is not sampled in FETCH: an outstanding request always completes.
//   TRAP
//   - Sticky until i_reset. o_trap = 1, no requests, o_instr_vld = 0.
//   - o_pc holds the faulting instruction's PC.
//   Other rules:
//   - A late ack arriving outside FETCH is ignored.
//   - Reset asserted mid-FETCH drops req asynchronously; any outstanding ack is discarded.
//   - Throughput: one instruction per (fetch latency + 1) cycles; at best 1 instruction per 2 cycles.
// TESTING
//   1. Reset release, zero-wait memory returning ADDI:
//      - req seen at cycle 1 with addr 0.
//      - instr_vld pulses at cycle 2.
//      - pc = 4 at cycle 3.
//   2. Ack delayed 3 cycles:
//      - req and addr stable for 3 cycles.
//      - o_instr updates only on the ack cycle.
//      - exactly one instr_vld pulse.
//   3. BEQ taken (pc_sel = 1, alu_data = 32'h40) -> pc = 32'h40.
//      BNE not taken (pc_sel = 0) -> pc + 4.
//   4. Illegal word (insn_vld = 0) at pc 32'h8:
//      - trap = 1, cause = 01, pc stays 32'h8.
//      - req stays 0 thereafter.
//   5. JALR target 32'h102 -> cause 10.
//      ACK_TIMEOUT = 4 with no ack -> cause 11 after 4 req cycles.
//   6. i_hold = 1 in EXEC -> HALT, req = 0.
//      i_hold = 0 -> fetch resumes at the updated pc.
//      Reset during HALT -> pc = RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the single-cycle RV32I core.
// Owns the PC and fetches each instruction over a variable-latency req/ack
// handshake. It then presents the instruction to ctrl_unit for exactly one
// execute cycle and applies the resulting next-PC choice. Any fault halts
// the stage in a sticky trap state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_hold,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_vld,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  input  logic        i_insn_vld,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
);

  localparam int unsigned       CNT_W       = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);
  localparam bit                TIMEOUT_EN  = (ACK_TIMEOUT != 0);
  localparam logic [31:0]       NOP_INSTR   = 32'h0000_0013;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_TRAP  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             vld_q, vld_d;
  logic             trap_q, trap_d;

  logic [CNT_W-1:0] cnt_inc_s;
  logic [31:0]      pc_four_s;
  logic [31:0]      next_pc_s;

  // Next-state, PC, instruction latch and timeout counter logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    cnt_inc_s = cnt_q + CNT_W'(1);
    pc_four_s = pc_q + 32'd4;
    next_pc_s = i_pc_sel ? i_alu_data : pc_four_s;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          instr_d = i_imem_rdata;
          state_d = S_EXEC;
        end else if (TIMEOUT_EN && (cnt_inc_s == TIMEOUT_CNT)) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_EXEC: begin
        // Faults leave the PC pointing at the offending instruction.
        if (!i_insn_vld) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (next_pc_s[1:0] != 2'b00) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MISALIGN;
        end else begin
          pc_d  = next_pc_s;
          cnt_d = '0;
          if (i_hold) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (!i_hold) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          state_d = S_HALT;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        // Unreachable encodings restart the fetch sequence cleanly.
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flags decoded from the next state so they come straight off flops.
  always_comb begin
    req_d  = (state_d == S_FETCH);
    vld_d  = (state_d == S_EXEC);
    trap_d = (state_d == S_TRAP);
  end

  // State and output registers; async assert, release synchronised externally.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      trap_q  <= trap_d;
    end
  end

  assign o_imem_req   = req_q;
  assign o_imem_addr  = pc_q;
  assign o_pc         = pc_q;
  assign o_pc_four    = pc_four_s;
  assign o_instr      = instr_q;
  assign o_instr_vld  = vld_q;
  assign o_trap       = trap_q;
  assign o_trap_cause = cause_q;

endmodule
